maxpool_2d: RTL and testbench



---
 rtl/maxpool_2d.sv | 112 +++++++++++
 tb/tb_maxpool_2d.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2d.sv
// maxpool_2d: 2x2 stride-2 per-channel max pooling over a raster-ordered
// IMG_W x IMG_H frame of 8-lane fp32 pixels. It has no backpressure, so
// every beat marked by input_valid is accepted.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   input_valid  d_in carries one pixel (8 channels) this cycle
//   d_in         8 lanes of fp32; lane i is channel i
//   d_out        8 lanes of fp32 pooled result; holds its last value
//   output_valid single-cycle pulse for each pooled result
//   o_sof        high with the first output of each output frame
//   o_eof        high with the last output of each output frame
//
// Build option: define MAXPOOL_2D_RELU_EN to fuse a ReLU at the output
// register. Any negative result, including -0, then becomes +0.

module maxpool_2d #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [31:0] d_in [7:0],
  output logic [31:0] d_out [7:0],
  output logic        output_valid,
  output logic        o_sof,
  output logic        o_eof
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int SLOTS = IMG_W / 2;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] slot;
  logic [31:0]   hold    [7:0];
  logic [31:0]   linebuf [SLOTS-1:0][7:0];
  logic [31:0]   h       [7:0];
  logic [31:0]   res     [7:0];

  // Sign-magnitude ordering: a positive value beats a negative one, so +0
  // beats -0. For two negatives, the smaller magnitude is the larger value.
  // When the bit patterns are equal, the function returns a.
  function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31])
      fp_max = a[31] ? b : a;
    else if (!a[31])
      fp_max = (b[30:0] > a[30:0]) ? b : a;
    else
      fp_max = (b[30:0] < a[30:0]) ? b : a;
  endfunction

  assign slot = SW'(col >> 1);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h[i]   = fp_max(hold[i], d_in[i]);
      res[i] = fp_max(linebuf[slot][i], h[i]);
`ifdef MAXPOOL_2D_RELU_EN
      if (res[i][31]) res[i] = '0;
`endif
    end
  end

  // The pixel hold register and the line buffer carry no reset. Each is
  // always written before it is read within a frame.
  always_ff @(posedge clk) begin
    if (input_valid) begin
      if (!col[0]) begin
        for (int i = 0; i < 8; i++) hold[i] <= d_in[i];
      end else if (!row[0]) begin
        for (int i = 0; i < 8; i++) linebuf[slot][i] <= h[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      row          <= '0;
      output_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      for (int i = 0; i < 8; i++) d_out[i] <= '0;
    end else begin
      output_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      if (input_valid) begin
        if (col[0] && row[0]) begin
          for (int i = 0; i < 8; i++) d_out[i] <= res[i];
          output_valid <= 1'b1;
          o_sof        <= (row == RW'(1)) && (col == CW'(1));
          o_eof        <= (row == ROW_LAST) && (col == COL_LAST);
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_2d.sv
// Testbench for maxpool_2d with an 8x8 frame. It checks the reset state,
// ramp frames (contiguous, gapped, and back-to-back), a table of 2x2 sign
// and ordering windows, and a reset applied in the middle of a frame.

module tb_maxpool_2d;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_valid;
  logic [31:0] d_in  [7:0];
  logic [31:0] d_out [7:0];
  logic        output_valid, o_sof, o_eof;

  maxpool_2d #(.IMG_W(8), .IMG_H(8)) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .d_in(d_in),
    .d_out(d_out), .output_valid(output_valid), .o_sof(o_sof), .o_eof(o_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic         sof;
    logic         eof;
    int           cyc;
  } out_t;

  typedef struct {
    logic [31:0] a, b, c, d, exp;
  } vec_t;

  out_t out_q[$];
  int   exp_cyc[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[5];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    out_t o;
    if (output_valid) begin
      for (int i = 0; i < 8; i++) o.data[i*32 +: 32] = d_out[i];
      o.sof = o_sof;
      o.eof = o_eof;
      o.cyc = cyc;
      out_q.push_back(o);
    end
  end

  function automatic logic [31:0] f2b(input int v);
    int e;
    logic [31:0] m;
    e = 0;
    for (int b = 0; b < 31; b++) if (((v >> b) & 1) == 1) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [255:0] px, input bit odd_odd);
    input_valid = 1'b1;
    for (int i = 0; i < 8; i++) d_in[i] = px[i*32 +: 32];
    if (odd_odd) exp_cyc.push_back(cyc + 1);
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic send_ramp(input bit gapped, input int nbeats);
    logic [255:0] px;
    for (int n = 0; n < nbeats; n++) begin
      int r, c;
      r = (n / 8) % 8;
      c = n % 8;
      for (int k = 0; k < 8; k++) px[k*32 +: 32] = f2b(r*8 + c + k);
      drive(px, (r % 2 == 1) && (c % 2 == 1));
      if (gapped) @(negedge clk);
    end
  endtask

  task automatic send_win(input vec_t v);
    logic [31:0] w;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        case ((r % 2) * 2 + (c % 2))
          0: w = v.a;
          1: w = v.b;
          2: w = v.c;
          default: w = v.d;
        endcase
        drive({8{w}}, 1'b0);
      end
  endtask

  task automatic clear_q();
    @(posedge clk);
    #1;
    out_q.delete();
    exp_cyc.delete();
    @(negedge clk);
  endtask

  task automatic check_ramp(input int nf, input string tag);
    logic [255:0] e;
    chk({tag, " count"}, 256'(out_q.size()), 256'(16 * nf));
    for (int j = 0; j < out_q.size() && j < 16 * nf; j++) begin
      int m, rr, cc;
      m  = j % 16;
      rr = m / 4;
      cc = m % 4;
      for (int k = 0; k < 8; k++) e[k*32 +: 32] = f2b((2*rr + 1)*8 + 2*cc + 1 + k);
      chk($sformatf("%s data[%0d]", tag, j), out_q[j].data, e);
      chk($sformatf("%s flags[%0d]", tag, j), {254'd0, out_q[j].sof, out_q[j].eof},
          {254'd0, m == 0, m == 15});
      if (j < exp_cyc.size())
        chk($sformatf("%s latency[%0d]", tag, j), 256'(out_q[j].cyc), 256'(exp_cyc[j]));
    end
  endtask

  initial begin
    logic [255:0] dv;
    vecs[0] = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hC0400000, 32'h80000000};
    vecs[1] = '{32'h80000000, 32'h00000000, 32'hC0A00000, 32'hC0A00000, 32'h00000000};
    vecs[2] = '{32'hBF800000, 32'hC0000000, 32'hC0800000, 32'hC1000000, 32'hBF800000};
    vecs[3] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0E00000, 32'h40400000};
    vecs[4] = '{32'hC0400000, 32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000};
`ifdef MAXPOOL_2D_RELU_EN
    vecs[0].exp = 32'h00000000;
    vecs[2].exp = 32'h00000000;
`endif

    rst = 1'b1;
    input_valid = 1'b0;
    for (int i = 0; i < 8; i++) d_in[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) dv[i*32 +: 32] = d_out[i];
    chk("reset d_out", dv, '0);
    chk("reset flags", {253'd0, output_valid, o_sof, o_eof}, '0);
    rst = 1'b0;
    @(negedge clk);

    send_ramp(1'b0, 64);
    repeat (3) @(negedge clk);
    if (out_q.size() > 0) chk("first d_out0", 256'(out_q[0].data[31:0]), 256'(32'h41100000));
    if (out_q.size() > 15) chk("last d_out0", 256'(out_q[15].data[31:0]), 256'(32'h427C0000));
    check_ramp(1, "frame");
    clear_q();

    send_ramp(1'b1, 64);
    repeat (3) @(negedge clk);
    check_ramp(1, "gapped");
    clear_q();

    send_ramp(1'b0, 64);
    send_ramp(1'b0, 64);
    repeat (3) @(negedge clk);
    check_ramp(2, "b2b");
    clear_q();

    for (int v = 0; v < 5; v++) begin
      send_win(vecs[v]);
      repeat (3) @(negedge clk);
      chk($sformatf("win%0d count", v), 256'(out_q.size()), 256'd16);
      for (int j = 0; j < out_q.size(); j++)
        chk($sformatf("win%0d data[%0d]", v, j), out_q[j].data, {8{vecs[v].exp}});
      clear_q();
    end

    send_ramp(1'b0, 20);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) dv[i*32 +: 32] = d_out[i];
    chk("midrst d_out", dv, '0);
    chk("midrst flags", {253'd0, output_valid, o_sof, o_eof}, '0);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    send_ramp(1'b0, 64);
    repeat (3) @(negedge clk);
    check_ramp(1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
